// File: rtl/alu_cmd_sched.sv
// alu_cmd_sched -- command scheduler for a shared 4-bit, 8-op combinational ALU.
//
// Accepts {A,B,op} commands on a valid/ready port into a small FIFO. Commands are issued
// one at a time to the external ALU. The block waits ALU_LAT cycles, captures the ALU
// result, and returns it on a valid/ready result port. The last completed result is also
// held for a 7-seg display decoder.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_ready is a registered "not full"
//   cmd_a, cmd_b, cmd_op          command operands and opcode
//   alu_a, alu_b, alu_op          operands held stable for the external ALU
//   alu_out                       external ALU result
//   res_valid/res_ready           result handshake
//   res_data, res_op              captured result and the opcode that produced it
//   disp_val                      last completed result, for the BCD 7-seg decoder
//   busy                          FSM active or FIFO non-empty
//   res_zero, res_ovf             (only with ALU_SCHED_FLAGS_EN) zero / signed add-sub overflow
//
// Build option: define ALU_SCHED_FLAGS_EN to add the res_zero/res_ovf flag outputs.
module alu_cmd_sched #(
  parameter int FIFO_DEPTH = 2,
  parameter int ALU_LAT    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [2:0] res_op,
  output logic [3:0] disp_val,
  output logic       busy
`ifdef ALU_SCHED_FLAGS_EN
  ,
  output logic       res_zero,
  output logic       res_ovf
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_q;
  logic [10:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            cmd_ready_q;
  logic [LW-1:0]   cnt_q;
  logic [3:0]      alu_a_q, alu_b_q;
  logic [2:0]      alu_op_q;
  logic            res_valid_q;
  logic [3:0]      res_data_q, disp_val_q;
  logic [2:0]      res_op_q;
  logic [10:0]     head;
  logic            push, pop;

  assign head = mem_q[rd_ptr_q];
  assign push = cmd_valid && cmd_ready_q;
  // A new command is taken either from IDLE or straight out of DONE on the result
  // handshake; the latter keeps back-to-back throughput at one result per ALU_LAT+2.
  assign pop  = (count_q != '0) &&
                ((state_q == IDLE) || ((state_q == DONE) && res_ready));
  assign count_d = count_q + CW'(push) - CW'(pop);

  // Payload storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_op};
  end

`ifdef ALU_SCHED_FLAGS_EN
  logic res_zero_q, res_ovf_q;
  logic [3:0] sum_w, diff_w;
  assign sum_w  = alu_a_q + alu_b_q;
  assign diff_w = alu_a_q - alu_b_q;

  // Signed 4-bit overflow, recomputed locally from the latched operands.
  function automatic logic ovf_f(input logic [3:0] a, input logic [3:0] b,
                                 input logic [2:0] op, input logic [3:0] s,
                                 input logic [3:0] d);
    case (op)
      3'b000:  ovf_f = (a[3] == b[3]) && (s[3] != a[3]);
      3'b001:  ovf_f = (a[3] != b[3]) && (d[3] != a[3]);
      default: ovf_f = 1'b0;
    endcase
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b0;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      disp_val_q  <= '0;
`ifdef ALU_SCHED_FLAGS_EN
      res_zero_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      // Registered full flag: no same-cycle bypass when a pop frees a slot.
      cmd_ready_q <= (count_d < CW'(FIFO_DEPTH));

      // Operands stay put until the next issue so the display never flickers.
      if (pop) begin
        alu_a_q  <= head[10:7];
        alu_b_q  <= head[6:3];
        alu_op_q <= head[2:0];
      end

      case (state_q)
        IDLE: begin
          if (pop) state_q <= ISSUE;
        end
        ISSUE: begin
          cnt_q   <= LW'(ALU_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            res_data_q  <= alu_out;
            res_op_q    <= alu_op_q;
            disp_val_q  <= alu_out;
            res_valid_q <= 1'b1;
`ifdef ALU_SCHED_FLAGS_EN
            res_zero_q  <= (alu_out == 4'd0);
            res_ovf_q   <= ovf_f(alu_a_q, alu_b_q, alu_op_q, sum_w, diff_w);
`endif
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= pop ? ISSUE : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign disp_val  = disp_val_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);
`ifdef ALU_SCHED_FLAGS_EN
  assign res_zero  = res_zero_q;
  assign res_ovf   = res_ovf_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sched.sv
// Testbench for alu_cmd_sched: models the external ALU, drives directed and random
// command/result traffic and checks against a queue-based reference model.
module tb_alu_cmd_sched;

  localparam int LAT   = 3;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_op;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_data, disp_val;
  logic [2:0] res_op;
  logic       busy;
`ifdef ALU_SCHED_FLAGS_EN
  logic       res_zero, res_ovf;
`endif

  always #5 clk = ~clk;

  alu_cmd_sched #(.FIFO_DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .disp_val(disp_val), .busy(busy)
`ifdef ALU_SCHED_FLAGS_EN
    , .res_zero(res_zero), .res_ovf(res_ovf)
`endif
  );

  // Behavioural model of the shared ALU.
  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0: alu_f = a + b;
      3'd1: alu_f = a - b;
      3'd2: alu_f = ~a;
      3'd3: alu_f = a & b;
      3'd4: alu_f = a | b;
      3'd5: alu_f = a ^ b;
      3'd6: alu_f = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      default: alu_f = (a == b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_a, alu_b, alu_op);

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } cmd_t;

  cmd_t       exp_q[$];
  logic [3:0] got_q[$];
  int         hs_q[$];
  int         n_chk = 0, n_err = 0;
  int         cyc = 0, last_acc = 0, last_rise = 0;
  logic       acc_flag = 1'b0;
  logic       prev_valid = 1'b0, prev_hs = 1'b0;
  logic [3:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic ovf_ref(input cmd_t c);
    int s;
    if (c.op == 3'd0)      s = int'($signed(c.a)) + int'($signed(c.b));
    else if (c.op == 3'd1) s = int'($signed(c.a)) - int'($signed(c.b));
    else                   s = 0;
    return (s > 7) || (s < -8);
  endfunction

  // Monitor on the falling edge: inputs seen here are the ones the next rising edge uses.
  always @(negedge clk) begin
    cmd_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      acc_flag   = 1'b0;
    end else begin
      chk("busy", busy, exp_q.size() != 0);
      if (prev_valid && !prev_hs) begin
        chk("hold_valid", res_valid, 1'b1);
        chk("hold_data", res_data, prev_data);
      end
      if (res_valid) chk("disp_val", disp_val, res_data);
      if (res_valid && !prev_valid) last_rise = cyc;
      if (res_valid && res_ready) begin
        hs_q.push_back(cyc);
        got_q.push_back(res_data);
        if (exp_q.size() == 0) begin
          chk("spurious_result", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("res_data", res_data, alu_f(e.a, e.b, e.op));
          chk("res_op", res_op, e.op);
`ifdef ALU_SCHED_FLAGS_EN
          chk("res_zero", res_zero, alu_f(e.a, e.b, e.op) == 4'd0);
          chk("res_ovf", res_ovf, ovf_ref(e));
`endif
        end
      end
      acc_flag = cmd_valid && cmd_ready;
      if (acc_flag) begin
        e.a = cmd_a; e.b = cmd_b; e.op = cmd_op;
        exp_q.push_back(e);
        last_acc = cyc + 1;  // numbered as the cycle ending at the accepting edge
      end
      prev_valid = res_valid;
      prev_hs    = res_valid && res_ready;
      prev_data  = res_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!acc_flag && n < 100);
    if (!acc_flag) chk("send_timeout", 1'b0, 1'b1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || res_valid) && n < 300) begin
      step();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 50) begin
      step();
      n++;
    end
    chk("wait_valid", res_valid, 1'b1);
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_disp", disp_val, 4'd0);
    chk("rst_alu_a", alu_a, 4'd0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", cmd_ready, 1'b1);

    // Reset in the middle of WAIT discards the command
    res_ready = 1'b1;
    send(4'd5, 4'd3, 3'd0);
    step(); step();
    rst = 1'b1;
    #1;
    chk("midrst_valid", res_valid, 1'b0);
    chk("midrst_disp", disp_val, 4'd0);
    chk("midrst_busy", busy, 1'b0);
    step(); step();
    rst = 1'b0;
    step();
    chk("midrst_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("midrst_no_result", res_valid, 1'b0);
      step();
    end
    chk("midrst_disp_after", disp_val, 4'd0);

    // Single command latency and value
    got_q.delete();
    res_ready = 1'b1;
    send(4'd5, 4'd3, 3'd0);
    drain();
    chk("latency", last_rise - last_acc, 2 + LAT);
    chk("add_5_3", got_q.size() > 0 ? got_q[0] : 4'hx, 4'd8);

    // Three commands with results held, then a fourth that must stall
    got_q.delete();
    res_ready = 1'b0;
    send(4'd2, 4'd5, 3'd1);
    send(4'hF, 4'd6, 3'd3);
    send(4'd7, 4'd7, 3'd7);
    cmd_a = 4'd1; cmd_b = 4'd1; cmd_op = 3'd0; cmd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("full_stall", acc_flag, 1'b0);
    end
    chk("full_ready", cmd_ready, 1'b0);
    res_ready = 1'b1;
    begin
      int n = 0;
      while (!acc_flag && n < 50) begin
        step();
        n++;
      end
      chk("stall_released", acc_flag, 1'b1);
    end
    cmd_valid = 1'b0;
    drain();
    chk("order_n", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("res0_sub", got_q[0], 4'hD);
      chk("res1_and", got_q[1], 4'h6);
      chk("res2_eq", got_q[2], 4'h1);
      chk("res3_add", got_q[3], 4'h2);
    end

    // Result held 10 cycles without handshake
    res_ready = 1'b0;
    send(4'd4, 4'd5, 3'd0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("hold10_valid", res_valid, 1'b1);
      chk("hold10_data", res_data, 4'h9);
      step();
    end
    drain();

    // Back-to-back throughput
    hs_q.delete();
    res_ready = 1'b1;
    send(4'd1, 4'd1, 3'd0);
    send(4'd2, 4'd2, 3'd4);
    send(4'd3, 4'd6, 3'd5);
    drain();
    chk("tput_n", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      chk("tput_1", hs_q[1] - hs_q[0], LAT + 2);
      chk("tput_2", hs_q[2] - hs_q[1], LAT + 2);
    end

    // Signed compare: -8 < 1
    got_q.delete();
    send(4'b1000, 4'b0001, 3'd6);
    drain();
    chk("slt_data", got_q.size() > 0 ? got_q[0] : 4'hx, 4'h1);
    chk("slt_disp", disp_val, 4'h1);
    chk("idle_not_busy", busy, 1'b0);

`ifdef ALU_SCHED_FLAGS_EN
    res_ready = 1'b0;
    send(4'd7, 4'd1, 3'd0);
    wait_valid();
    chk("flag_add_data", res_data, 4'h8);
    chk("flag_add_ovf", res_ovf, 1'b1);
    chk("flag_add_zero", res_zero, 1'b0);
    drain();
    res_ready = 1'b0;
    send(4'd3, 4'd3, 3'd1);
    wait_valid();
    chk("flag_sub_zero", res_zero, 1'b1);
    chk("flag_sub_ovf", res_ovf, 1'b0);
    drain();
`endif

    // Randomized traffic against the queue model
    cmd_valid = 1'b0;
    for (int i = 0; i < 800; i++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      if (!cmd_valid || acc_flag) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_a     = 4'($urandom);
        cmd_b     = 4'($urandom);
        cmd_op    = 3'($urandom);
      end
      step();
    end
    cmd_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
